// File: rtl/cpu_bus_master.sv
// CPU-side master for the C1/A1/D1 cache bus.
// Accepts one valid/ready request at a time, runs the two-beat address phase,
// a turnaround cycle and the response wait, then returns a single completion
// pulse carrying 32-bit read data or an error flag. Keeps simple statistics.
module cpu_bus_master #(
   parameter int unsigned ADDR_W   = 19,
   parameter int unsigned OFFSET_W = 4,
   parameter int unsigned A1_W     = 15,
   parameter int unsigned D1_W     = 16,
   parameter int unsigned C1_W     = 3,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [C1_W-1:0]   req_cmd,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [C1_W-1:0]   c1_out,
   output logic              c1_oe,
   input  logic [C1_W-1:0]   c1_in,
   output logic [A1_W-1:0]   a1_out,
   output logic              a1_oe,
   output logic [D1_W-1:0]   d1_out,
   output logic              d1_oe,
   input  logic [D1_W-1:0]   d1_in,
   input  logic              stat_clear,
   output logic [CNT_W-1:0]  stat_txn,
   output logic [CNT_W-1:0]  stat_wait
);

   // Wide enough to hold TIMEOUT itself.
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StAddr1 = 3'd1;
   localparam logic [2:0] StAddr2 = 3'd2;
   localparam logic [2:0] StTurn  = 3'd3;
   localparam logic [2:0] StWait  = 3'd4;
   localparam logic [2:0] StData2 = 3'd5;
   localparam logic [2:0] StResp  = 3'd6;

   localparam logic [C1_W-1:0] CmdRd8  = C1_W'(1);
   localparam logic [C1_W-1:0] CmdRd16 = C1_W'(2);
   localparam logic [C1_W-1:0] CmdRd32 = C1_W'(3);
   localparam logic [C1_W-1:0] CmdInv  = C1_W'(4);
   localparam logic [C1_W-1:0] CmdWr8  = C1_W'(5);
   localparam logic [C1_W-1:0] CmdWr16 = C1_W'(6);
   localparam logic [C1_W-1:0] CmdWr32 = C1_W'(7);
   localparam logic [C1_W-1:0] CmdRsp  = C1_W'(7);

   logic [2:0]        state_q, state_d;
   logic [C1_W-1:0]   cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  stat_txn_q, stat_txn_d;
   logic [CNT_W-1:0]  stat_wait_q, stat_wait_d;

   logic req_legal;
   logic is_read, is_write;

   // Alignment and command legality of the incoming request.
   always_comb begin
      req_legal = 1'b1;
      if (req_cmd == '0) begin
         req_legal = 1'b0;
      end
      if ((req_cmd == CmdRd16 || req_cmd == CmdWr16) && req_addr[0]) begin
         req_legal = 1'b0;
      end
      if ((req_cmd == CmdRd32 || req_cmd == CmdWr32) && (req_addr[1:0] != 2'b00)) begin
         req_legal = 1'b0;
      end
   end

   assign is_read  = (cmd_q == CmdRd8) || (cmd_q == CmdRd16) || (cmd_q == CmdRd32);
   assign is_write = (cmd_q == CmdWr8) || (cmd_q == CmdWr16) || (cmd_q == CmdWr32);

   // Transaction sequencing, response capture and timeout.
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               cmd_d   = req_cmd;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = ~req_legal;
               state_d = req_legal ? StAddr1 : StResp;
            end
         end
         StAddr1: state_d = StAddr2;
         StAddr2: state_d = StTurn;
         StTurn: begin
            wcnt_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            // A response in the same cycle the counter reaches TIMEOUT still succeeds.
            if (c1_in == CmdRsp) begin
               if (is_read) begin
                  rdata_d[15:0] = (cmd_q == CmdRd8) ? {8'h00, d1_in[7:0]} : d1_in[15:0];
               end
               state_d = (cmd_q == CmdRd32) ? StData2 : StResp;
            end else if (wcnt_q == WAIT_W'(TIMEOUT)) begin
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               wcnt_d = wcnt_q + WAIT_W'(1);
            end
         end
         StData2: begin
            rdata_d[31:16] = d1_in[15:0];
            state_d        = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Statistics; a clear overrides a same-cycle update.
   always_comb begin
      stat_txn_d  = stat_txn_q;
      stat_wait_d = stat_wait_q;
      if (stat_clear) begin
         stat_txn_d  = '0;
         stat_wait_d = '0;
      end else if (state_q == StResp && !err_q) begin
         stat_txn_d  = stat_txn_q + CNT_W'(1);
         stat_wait_d = stat_wait_q + CNT_W'(wcnt_q);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cmd_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         wcnt_q      <= '0;
         stat_txn_q  <= '0;
         stat_wait_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         wcnt_q      <= wcnt_d;
         stat_txn_q  <= stat_txn_d;
         stat_wait_q <= stat_wait_d;
      end
   end

   // Bus drive for the two address beats; released in every other state.
   always_comb begin
      c1_oe  = 1'b0;
      c1_out = '0;
      a1_oe  = 1'b0;
      a1_out = '0;
      d1_oe  = 1'b0;
      d1_out = '0;
      case (state_q)
         StAddr1: begin
            c1_oe  = 1'b1;
            c1_out = cmd_q;
            a1_oe  = 1'b1;
            a1_out = addr_q[ADDR_W-1:OFFSET_W];
            if (is_write) begin
               d1_oe  = 1'b1;
               d1_out = (cmd_q == CmdWr8) ? D1_W'(wdata_q[7:0]) : D1_W'(wdata_q[15:0]);
            end
         end
         StAddr2: begin
            c1_oe  = 1'b1;
            c1_out = cmd_q;
            a1_oe  = 1'b1;
            a1_out = A1_W'(addr_q[OFFSET_W-1:0]);
            if (is_write) begin
               d1_oe  = 1'b1;
               d1_out = (cmd_q == CmdWr32) ? D1_W'(wdata_q[31:16]) : '0;
            end
         end
         default: begin
         end
      endcase
   end

   // Request/response handshake outputs.
   always_comb begin
      req_ready = (state_q == StIdle);
      rsp_valid = (state_q == StResp);
      rsp_err   = rsp_valid & err_q;
      rsp_rdata = (rsp_valid && !err_q) ? rdata_q : '0;
   end

   assign stat_txn  = stat_txn_q;
   assign stat_wait = stat_wait_q;

endmodule
